// File: rtl/mem_port_arbiter_pkg.sv
// Shared word width, opcode constants and read-tag type for the tape-cell memory port.
// Pure declarations: no latency and no backpressure of its own.
// The read tag names the issuing core for the fixed-latency return path.
package tb_pkg;
    localparam int WORD_W    = 16;
    localparam int MAX_CORES = 16;
    localparam int ID_W      = 4;

    localparam logic [3:0] PLUS  = 4'h1;
    localparam logic [3:0] MINUS = 4'h2;
    localparam logic [3:0] BRZ   = 4'h5;

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } rd_tag_t;

    function automatic logic [MAX_CORES-1:0] onehot(input logic [ID_W-1:0] idx, input int n);
        logic [MAX_CORES-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_CORES; i++) begin
            r[i] = (i < n) && (idx == ID_W'(i));
        end
        return r;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin pick: first asserted request scanning upward from rr, with wrap.
// Purely combinational, zero latency.
// No backpressure; the caller decides whether the pick becomes a grant.
module rr_pick #(
    parameter int NCORES = 4,
    parameter int RRW    = $clog2(NCORES)
) (
    input  logic [NCORES-1:0] req,
    input  logic [RRW-1:0]    rr,
    output logic              any,
    output logic [RRW-1:0]    winner,
    output logic [NCORES-1:0] gnt_oh
);
    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int k = 0; k < NCORES; k++) begin
            int idx;
            idx = int'(rr) + k;
            if (idx >= NCORES) begin
                idx = idx - NCORES;
            end
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = RRW'(idx);
            end
        end
        gnt_oh = '0;
        for (int i = 0; i < NCORES; i++) begin
            gnt_oh[i] = any && (winner == RRW'(i));
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit memory port among NCORES select units; routes read data back in order.
// Grant/issue same cycle; read return registered MEM_LAT+1 cycles after issue.
// mem_ready=0 withholds all grants; requesters hold req until granted.
module mem_port_arbiter
    import tb_pkg::*;
#(
    parameter int NCORES  = 4,
    parameter int MEM_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCORES-1:0]        req,
    input  logic [NCORES-1:0]        req_we,
    input  logic [NCORES*WORD_W-1:0] req_addr,
    input  logic [NCORES*WORD_W-1:0] req_wdata,
    output logic [NCORES-1:0]        gnt,
    input  logic                     mem_ready,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [WORD_W-1:0]        mem_addr,
    output logic [WORD_W-1:0]        mem_wdata,
    input  logic [WORD_W-1:0]        mem_rdata,
    output logic [NCORES-1:0]        rsp_valid,
    output logic [WORD_W-1:0]        rsp_data,
    output logic                     busy
);
    localparam int RRW = $clog2(NCORES);

    logic [RRW-1:0]    rr_q, rr_d;
    logic              pick_any;
    logic [RRW-1:0]    winner;
    logic [NCORES-1:0] pick_gnt;
    logic              grant;

    rd_tag_t [MEM_LAT-1:0] pipe_q, pipe_d;
    logic [NCORES-1:0]     rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0]     rsp_data_q, rsp_data_d;

    rr_pick #(.NCORES(NCORES), .RRW(RRW)) u_pick (
        .req    (req),
        .rr     (rr_q),
        .any    (pick_any),
        .winner (winner),
        .gnt_oh (pick_gnt)
    );

    always_comb begin
        // Grants are suppressed during reset so nothing issues into a pipe being cleared.
        grant     = pick_any && mem_ready && !rst;
        gnt       = grant ? pick_gnt : '0;
        mem_en    = grant;
        mem_we    = req_we[winner];
        mem_addr  = req_addr[int'(winner)*WORD_W +: WORD_W];
        mem_wdata = req_wdata[int'(winner)*WORD_W +: WORD_W];

        rr_d = rr_q;
        if (grant) begin
            rr_d = (winner == RRW'(NCORES-1)) ? '0 : winner + RRW'(1);
        end

        pipe_d       = '0;
        pipe_d[0].v  = grant && !mem_we;
        pipe_d[0].id = ID_W'(winner);
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (pipe_q[MEM_LAT-1].v) begin
            for (int i = 0; i < NCORES; i++) begin
                rsp_valid_d[i] = (pipe_q[MEM_LAT-1].id == ID_W'(i));
            end
            rsp_data_d = mem_rdata;
        end

        busy = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            busy = busy | pipe_q[i].v;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q        <= '0;
            pipe_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_q        <= rr_d;
            pipe_q      <= pipe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
endmodule
